// File: rtl/xup_and_vector_tester_if.sv
// Stimulus/response bus between the AND vector tester
// and the SIZE-bit two-input gate it exercises.
interface xup_and_vector_tester_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] a_out;
  logic [SIZE-1:0] b_out;
  logic [SIZE-1:0] y_in;

  modport master (
    output a_out,
    output b_out,
    input  y_in
  );

  modport slave (
    input  a_out,
    input  b_out,
    output y_in
  );
endinterface

// File: rtl/xup_and_vector_tester.sv
// Drives k / bitrev(k) into an AND gate, checks y after SETTLE cycles.
// XUP_AND_TESTER_FAIL_CAPTURE_EN: latch the first failing vector.
module xup_and_vector_tester #(
  parameter int SIZE    = 8,
  parameter int NUM_VEC = 256,
  parameter int SETTLE  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  xup_and_vector_tester_if.master gate,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [SIZE-1:0]         fail_a,
  output logic [SIZE-1:0]         fail_b,
  output logic [SIZE-1:0]         fail_y
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [SIZE-1:0] K_LAST   = SIZE'(NUM_VEC - 1);

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [15:0]     err_q, err_d;
  logic            pass_q, pass_d;

  logic            launch;
  logic            mismatch;
  logic [SIZE-1:0] k_inc;

  function automatic logic [SIZE-1:0] bit_rev(
    input logic [SIZE-1:0] v
  );
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i] = v[SIZE-1-i];
    return r;
  endfunction

  assign launch   = start &&
                    (state_q == S_IDLE || state_q == S_DONE);
  assign mismatch = gate.y_in != (a_q & b_q);
  assign k_inc    = k_q + 1'b1;

  // Sequencer: settle count, compare, advance to next vector.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (1'b1)
      launch: begin
        state_d = S_APPLY;
        k_d     = '0;
        cnt_d   = '0;
        a_d     = '0;
        b_d     = bit_rev('0);
        err_d   = '0;
        pass_d  = 1'b0;
      end
      state_q == S_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      state_q == S_CHECK: begin
        if (mismatch && err_q != 16'hFFFF)
          err_d = err_q + 16'd1;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          pass_d  = (err_d == 16'd0);
        end else begin
          state_d = S_APPLY;
          k_d     = k_inc;
          a_d     = k_inc;
          b_d     = bit_rev(k_inc);
        end
      end
      default: ;
    endcase
  end

  // Sequencer and stimulus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign gate.a_out = a_q;
  assign gate.b_out = b_q;
  assign busy       = (state_q == S_APPLY) ||
                      (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;

`ifdef XUP_AND_TESTER_FAIL_CAPTURE_EN
  logic [SIZE-1:0] fa_q, fa_d;
  logic [SIZE-1:0] fb_q, fb_d;
  logic [SIZE-1:0] fy_q, fy_d;

  // Clear on launch, grab the first miss of the run.
  always_comb begin
    fa_d = fa_q;
    fb_d = fb_q;
    fy_d = fy_q;
    if (launch) begin
      fa_d = '0;
      fb_d = '0;
      fy_d = '0;
    end else if (state_q == S_CHECK && mismatch &&
                 err_q == 16'd0) begin
      fa_d = a_q;
      fb_d = b_q;
      fy_d = gate.y_in;
    end
  end

  // First-failure capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa_q <= '0;
      fb_q <= '0;
      fy_q <= '0;
    end else begin
      fa_q <= fa_d;
      fb_q <= fb_d;
      fy_q <= fy_d;
    end
  end

  assign fail_a = fa_q;
  assign fail_b = fb_q;
  assign fail_y = fy_q;
`else
  assign fail_a = '0;
  assign fail_b = '0;
  assign fail_y = '0;
`endif

endmodule

// File: tb/tb_xup_and_vector_tester.sv
// Bench for xup_and_vector_tester: gate models, run scoreboard.
// Three instances: main (SETTLE=4), short settle (2), single vector.
module tb_xup_and_vector_tester;

  typedef struct {
    int         lat;
    int         errs;
    bit         exact;
    logic       pass;
    logic [7:0] fa;
    logic [7:0] fb;
    logic [7:0] fy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] st    = 3'b000;
  int         mode  = 0;

  always #5 clk = ~clk;

  xup_and_vector_tester_if #(.SIZE(8)) ga ();
  xup_and_vector_tester_if #(.SIZE(8)) gb ();
  xup_and_vector_tester_if #(.SIZE(8)) gc ();

  logic [2:0]  busy, done, pass;
  logic [15:0] err [3];
  logic [7:0]  fa [3];
  logic [7:0]  fb [3];
  logic [7:0]  fy [3];

  xup_and_vector_tester #(
    .SIZE(8), .NUM_VEC(256), .SETTLE(4)
  ) u_a (
    .clk(clk), .reset(reset), .start(st[0]), .gate(ga),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .fail_a(fa[0]), .fail_b(fb[0]),
    .fail_y(fy[0])
  );

  xup_and_vector_tester #(
    .SIZE(8), .NUM_VEC(256), .SETTLE(2)
  ) u_b (
    .clk(clk), .reset(reset), .start(st[1]), .gate(gb),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .fail_a(fa[1]), .fail_b(fb[1]),
    .fail_y(fy[1])
  );

  xup_and_vector_tester #(
    .SIZE(8), .NUM_VEC(1), .SETTLE(4)
  ) u_c (
    .clk(clk), .reset(reset), .start(st[2]), .gate(gc),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err[2]), .fail_a(fa[2]), .fail_b(fb[2]),
    .fail_y(fy[2])
  );

  // Gate models: 0 good, 1 y[3] stuck at 0, 2 three-cycle delay.
  logic [7:0] pa [3];
  logic [7:0] pb [3];
  logic [7:0] pc [3];

  always @(posedge clk) begin
    pa[0] <= ga.a_out & ga.b_out;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pb[0] <= gb.a_out & gb.b_out;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    pc[0] <= gc.a_out & gc.b_out;
    pc[1] <= pc[0];
    pc[2] <= pc[1];
  end

  function automatic logic [7:0] gate_y(
    input int m, input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] dly
  );
    if (m == 0) return a & b;
    if (m == 1) return (a & b) & 8'hF7;
    return dly;
  endfunction

  assign ga.y_in = gate_y(mode, ga.a_out, ga.b_out, pa[2]);
  assign gb.y_in = gate_y(mode, gb.a_out, gb.b_out, pb[2]);
  assign gc.y_in = gate_y(mode, gc.a_out, gc.b_out, pc[2]);

  // Reference outcome of one run against gate model m.
  function automatic exp_t model(
    input int nvec, input int settle, input int m
  );
    exp_t e;
    logic [7:0] a, b, x, y;
    e.lat   = nvec * (settle + 1);
    e.exact = !(m == 2 && settle < 3);
    e.errs  = 0;
    e.fa    = 8'h00;
    e.fb    = 8'h00;
    e.fy    = 8'h00;
    for (int k = 0; k < nvec; k++) begin
      a = 8'(k);
      for (int i = 0; i < 8; i++) b[i] = a[7-i];
      x = a & b;
      y = (m == 1) ? (x & 8'hF7) : x;
      if (y != x) begin
        e.errs++;
`ifdef XUP_AND_TESTER_FAIL_CAPTURE_EN
        if (e.errs == 1) begin
          e.fa = a;
          e.fb = b;
          e.fy = y;
        end
`endif
      end
    end
    e.pass = (e.errs == 0);
    return e;
  endfunction

  // Launch a run on instance w; optional start poke or reset abort.
  task automatic run(input int w, input int inj, input int abort_at);
    exp_t e;
    int   n;
    @(negedge clk);
    st[w] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy[w] !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise dut%0d: got %b want 1", w, busy[w]);
    end
    checks++;
    if (err[w] !== 16'd0 || pass[w] !== 1'b0 ||
        fa[w] !== 8'd0 || fb[w] !== 8'd0 || fy[w] !== 8'd0) begin
      errors++;
      $display("FAIL start_clear dut%0d: err=%0d pass=%b f=%h/%h/%h want 0",
               w, err[w], pass[w], fa[w], fb[w], fy[w]);
    end
    @(negedge clk);
    st[w] = 1'b0;
    n = 0;
    while (n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == abort_at) begin
        reset = 1'b1;
        #1;
        checks++;
        if (ga.a_out !== 8'd0 || ga.b_out !== 8'd0 ||
            busy[0] !== 1'b0 || done[0] !== 1'b0 ||
            pass[0] !== 1'b0 || err[0] !== 16'd0 ||
            fa[0] !== 8'd0 || fb[0] !== 8'd0 || fy[0] !== 8'd0) begin
          errors++;
          $display("FAIL reset_mid_run: a=%h b=%h busy=%b done=%b err=%0d want all 0",
                   ga.a_out, ga.b_out, busy[0], done[0], err[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (n == inj) st[w] = 1'b1;
      if (n == inj + 1) st[w] = 1'b0;
      if (done[w] === 1'b1) break;
    end
    e = sb.pop_front();
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL done_latency dut%0d: got %0d want %0d", w, n, e.lat);
    end
    checks++;
    if (busy[w] !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall dut%0d: got %b want 0", w, busy[w]);
    end
    checks++;
    if (e.exact && (err[w] !== 16'(e.errs) || pass[w] !== e.pass)) begin
      errors++;
      $display("FAIL result dut%0d: err=%0d pass=%b want err=%0d pass=%b",
               w, err[w], pass[w], e.errs, e.pass);
    end else if (!e.exact && (err[w] === 16'd0 || pass[w] !== 1'b0)) begin
      errors++;
      $display("FAIL short_settle dut%0d: err=%0d pass=%b want err>0 pass=0",
               w, err[w], pass[w]);
    end
    checks++;
    if (fa[w] !== e.fa || fb[w] !== e.fb || fy[w] !== e.fy) begin
      errors++;
      $display("FAIL fail_capture dut%0d: got %h/%h/%h want %h/%h/%h",
               w, fa[w], fb[w], fy[w], e.fa, e.fb, e.fy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done[w] !== 1'b1 || err[w] !== 16'(e.errs) && e.exact) begin
      errors++;
      $display("FAIL done_hold dut%0d: done=%b err=%0d", w, done[w], err[w]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (busy[w] !== 1'b0 || done[w] !== 1'b0 ||
          pass[w] !== 1'b0 || err[w] !== 16'd0 ||
          fa[w] !== 8'd0 || fb[w] !== 8'd0 || fy[w] !== 8'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b pass=%b err=%0d",
                 w, busy[w], done[w], pass[w], err[w]);
      end
    end
    checks++;
    if (ga.a_out !== 8'd0 || ga.b_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_stim: a=%h b=%h want 00/00", ga.a_out, ga.b_out);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_gate();
    mode = 0;
    sb.push_back(model(256, 4, 0));
    run(0, -10, -1);
  endtask

  task automatic test_stuck_fault();
    mode = 1;
    sb.push_back(model(256, 4, 1));
    run(0, -10, -1);
  endtask

  task automatic test_restart_from_done();
    mode = 0;
    sb.push_back(model(256, 4, 0));
    run(0, -10, -1);
  endtask

  task automatic test_settle();
    mode = 2;
    sb.push_back(model(256, 4, 2));
    run(0, -10, -1);
    sb.push_back(model(256, 2, 2));
    run(1, -10, -1);
    mode = 0;
  endtask

  task automatic test_start_ignored();
    mode = 0;
    sb.push_back(model(256, 4, 0));
    run(0, 100, -1);
  endtask

  task automatic test_reset_mid_run();
    mode = 0;
    run(0, -10, 500);
    repeat (2) @(negedge clk);
    sb.push_back(model(256, 4, 0));
    run(0, -10, -1);
  endtask

  task automatic test_single_vector();
    mode = 0;
    sb.push_back(model(1, 4, 0));
    run(2, -10, -1);
  endtask

  initial begin
    test_reset();
    test_good_gate();
    test_stuck_fault();
    test_restart_from_done();
    test_settle();
    test_start_ignored();
    test_reset_mid_run();
    test_single_vector();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
